// File: rtl/rr_mux4_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mux_arb_pkg
//  Purpose  : Shared constants, FSM state type and the round-robin winner
//             function for the rr_mux4_arbiter block.
//  Revision : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Searches sel+1, sel+2, ... (mod N_REQ) and returns the first requester
  // found. When nothing requests, the pointer is returned unchanged.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] sel,
                                               input logic [N_REQ-1:0] req);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = sel;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = sel + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux4_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : rr_mux4_arbiter_if
//  Purpose   : Bundles the four requester lanes, the muxed output port and
//              the arbiter status signals.
//              master modport : arbiter side
//              slave modport  : requesters + downstream side
//  Revision  : 1.0 - initial release
// ============================================================================
interface rr_mux4_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          s_valid;
  logic [4*DATA_W-1:0] s_data;
  logic [3:0]          s_last;
  logic [3:0]          s_ready;
  logic                m_valid;
  logic [DATA_W-1:0]   m_data;
  logic                m_last;
  logic                m_ready;
  logic [1:0]          sel;
  logic                busy;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, sel, busy
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, sel, busy
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux4_arbiter_pick4.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick4
//  Purpose  : Combinational rotate-priority encoder. The requester just after
//             ptr has highest priority; any flags that someone is requesting.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  assign winner = rr_next(ptr, req);
  assign any    = |req;

endmodule
`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux4_arbiter
//  Purpose  : Round-robin arbiter and sequencer for a shared 4:1 data mux.
//             Grants one requester per packet, holds the grant until the
//             packet ends or a beat-count watchdog forces release, and
//             forwards the owner's beats to the single output port.
//  Options  : RR_ARB_STATS_EN - adds pkt_cnt / wdog_cnt statistic outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_mux4_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux4_arbiter_if.master bus
`ifdef RR_ARB_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [7:0]        wdog_cnt
`endif
);

  localparam int              CNT_W    = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic              r_busy, w_busy_nxt;

  logic [SEL_W-1:0]  w_winner;
  logic              w_any;
  logic [DATA_W-1:0] w_lane [N_REQ];
  logic              w_m_valid;
  logic              w_m_last;
  logic [N_REQ-1:0]  w_s_ready;
  logic              w_xfer;

  // Split the packed data bus into one lane per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign w_lane[gi] = bus.s_data[gi*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .req    (bus.s_valid),
    .ptr    (r_sel),
    .winner (w_winner),
    .any    (w_any)
  );

  // Output steering: only the owner sees ready, and only while granted.
  always_comb begin
    w_m_valid = 1'b0;
    w_m_last  = 1'b0;
    w_s_ready = '0;
    if (r_state == GRANT) begin
      w_m_valid        = bus.s_valid[r_sel];
      w_m_last         = bus.s_last[r_sel] | (r_beat_cnt == LAST_CNT);
      w_s_ready[r_sel] = bus.m_ready;
    end
  end

  assign w_xfer      = w_m_valid & bus.m_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_last  = w_m_last;
  assign bus.s_ready = w_s_ready;
  // Data follows the registered select, so it is stable while the owner holds.
  assign bus.m_data  = w_lane[r_sel];
  assign bus.sel     = r_sel;
  assign bus.busy    = r_busy;

  // Next-state logic: pick a winner in IDLE, count beats and release in GRANT.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_beat_cnt_nxt = r_beat_cnt;
    w_busy_nxt     = r_busy;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_sel_nxt   = w_winner;
          w_busy_nxt  = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_xfer) begin
          if (w_m_last) begin
            // sel keeps the last owner so it acts as the round-robin pointer.
            w_beat_cnt_nxt = '0;
            w_busy_nxt     = 1'b0;
            w_state_nxt    = IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State registers; sel resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_sel      <= SEL_W'(N_REQ - 1);
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

`ifdef RR_ARB_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [7:0]  r_wdog_cnt;

  // Packet and forced-release statistics; both wrap on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_wdog_cnt <= '0;
    end else if (w_xfer && w_m_last) begin
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (!bus.s_last[r_sel]) begin
        r_wdog_cnt <= r_wdog_cnt + 8'd1;
      end
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign wdog_cnt = r_wdog_cnt;
`endif

endmodule
`default_nettype wire
